// File: rtl/fp_mul_pkg.sv
// Shared constants, binary32 field layout and operand classification for fp_mul.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package fp_mul_pkg;

    localparam int FP_W     = 32;
    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;
    localparam int EXP_BIAS = 127;
    localparam int LATENCY  = 5;

    // Significand including the hidden bit, its full product, and the
    // signed working exponent (wide enough for 1+254+254-127 plus two increments).
    localparam int MANT_W = FRAC_W + 1;
    localparam int PROD_W = 2 * MANT_W;
    localparam int SEXP_W = 10;

    localparam logic [FP_W-1:0] QNAN = 32'h7FC0_0000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    // ZERO is encoded as 0 so a cleared pipeline stage naturally means 0x0.
    typedef enum logic [1:0] {
        ZERO = 2'd0,
        NORM = 2'd1,
        INF  = 2'd2,
        NAN  = 2'd3
    } fclass_e;

    // Subnormal operands fold into ZERO (no subnormal support).
    function automatic fclass_e classify(input fp32_t x);
        if (x.exp == {EXP_W{1'b1}}) begin
            return (x.frac != '0) ? NAN : INF;
        end
        if (x.exp == '0) begin
            return ZERO;
        end
        return NORM;
    endfunction

endpackage

// File: rtl/fp_mul_round.sv
// Round-to-nearest-even of a normalized significand plus exponent range check.
// Latency: 0 (combinational).
// Backpressure: none.
// Ports: mant/guard/sticky/exp_in = normalized product; frac/exp_out = rounded
// fields; overflow/underflow = final exponent out of the normal range.
module fp_mul_round
    import fp_mul_pkg::*;
(
    input  logic [MANT_W-1:0]        mant,
    input  logic                     guard,
    input  logic                     sticky,
    input  logic signed [SEXP_W-1:0] exp_in,
    output logic [FRAC_W-1:0]        frac,
    output logic [EXP_W-1:0]         exp_out,
    output logic                     overflow,
    output logic                     underflow
);

    logic                     round_up;
    logic                     carry;
    logic [MANT_W:0]          sum;
    logic signed [SEXP_W-1:0] exp_adj;
    logic                     unused_hidden;

    always_comb begin
        round_up = guard & (sticky | mant[0]);
        sum      = {1'b0, mant} + {{MANT_W{1'b0}}, round_up};
        // A carry out can only come from an all-ones significand, so the
        // renormalized value is exactly 1.0: fraction bits are already zero.
        carry    = sum[MANT_W];
        frac     = sum[FRAC_W-1:0];
        exp_adj  = exp_in + $signed({{(SEXP_W-1){1'b0}}, carry});
        exp_out  = exp_adj[EXP_W-1:0];
        overflow  = (exp_adj >= 10'sd255);
        underflow = (exp_adj <= 10'sd0);
    end

    assign unused_hidden = sum[MANT_W-1];

endmodule

// File: rtl/fp_mul.sv
// Pipelined binary32 multiplier, round-to-nearest-even, flush-to-zero.
// Latency: 5 clocks (operands sampled on one edge, product on result after the 5th edge counting it).
// Backpressure: none; free-running, one operand pair accepted every clock.
// Ports: clock, aclr (async active-low), dataa/datab operands, result product.
// Optional FP_MUL_FLAGS_EN adds overflow/underflow/nan/zero aligned with result.
module fp_mul
    import fp_mul_pkg::*;
(
    input  logic            clock,
    input  logic            aclr,
    input  logic [FP_W-1:0] dataa,
    input  logic [FP_W-1:0] datab,
    output logic [FP_W-1:0] result
`ifdef FP_MUL_FLAGS_EN
    ,
    output logic            overflow,
    output logic            underflow,
    output logic            nan,
    output logic            zero
`endif
);

    // ---------------- S1: classify, sign, exponent sum ----------------
    fp32_t                    op_a;
    fp32_t                    op_b;
    fclass_e                  cls_a;
    fclass_e                  cls_b;
    fclass_e                  cls_in;
    logic signed [SEXP_W-1:0] exp_sum;

    assign op_a = dataa;
    assign op_b = datab;

    always_comb begin
        cls_a = classify(op_a);
        cls_b = classify(op_b);
        if (cls_a == NAN || cls_b == NAN) begin
            cls_in = NAN;
        end else if ((cls_a == INF && cls_b == ZERO) || (cls_a == ZERO && cls_b == INF)) begin
            cls_in = NAN;
        end else if (cls_a == INF || cls_b == INF) begin
            cls_in = INF;
        end else if (cls_a == ZERO || cls_b == ZERO) begin
            cls_in = ZERO;
        end else begin
            cls_in = NORM;
        end
        exp_sum = $signed({2'b00, op_a.exp}) + $signed({2'b00, op_b.exp})
                - 10'(EXP_BIAS);
    end

    logic                     s1_sign;
    fclass_e                  s1_cls;
    logic signed [SEXP_W-1:0] s1_exp;
    logic [MANT_W-1:0]        s1_ma;
    logic [MANT_W-1:0]        s1_mb;

    always_ff @(posedge clock or negedge aclr) begin
        if (!aclr) begin
            s1_sign <= 1'b0;
            s1_cls  <= ZERO;
            s1_exp  <= '0;
            s1_ma   <= '0;
            s1_mb   <= '0;
        end else begin
            s1_sign <= op_a.sign ^ op_b.sign;
            s1_cls  <= cls_in;
            s1_exp  <= exp_sum;
            s1_ma   <= {1'b1, op_a.frac};
            s1_mb   <= {1'b1, op_b.frac};
        end
    end

    // ---------------- S2: significand multiply ----------------
    logic                     s2_sign;
    fclass_e                  s2_cls;
    logic signed [SEXP_W-1:0] s2_exp;
    logic [PROD_W-1:0]        s2_prod;

    always_ff @(posedge clock or negedge aclr) begin
        if (!aclr) begin
            s2_sign <= 1'b0;
            s2_cls  <= ZERO;
            s2_exp  <= '0;
            s2_prod <= '0;
        end else begin
            s2_sign <= s1_sign;
            s2_cls  <= s1_cls;
            s2_exp  <= s1_exp;
            s2_prod <= s1_ma * s1_mb;
        end
    end

    // ---------------- S3: normalize, guard/sticky ----------------
    // Product of two [1,2) significands lies in [1,4): at most one right shift.
    logic [MANT_W-1:0]        nrm_mant;
    logic                     nrm_guard;
    logic                     nrm_sticky;
    logic signed [SEXP_W-1:0] nrm_exp;

    always_comb begin
        if (s2_prod[PROD_W-1]) begin
            nrm_mant   = s2_prod[PROD_W-1:MANT_W];
            nrm_guard  = s2_prod[MANT_W-1];
            nrm_sticky = |s2_prod[MANT_W-2:0];
            nrm_exp    = s2_exp + 10'sd1;
        end else begin
            nrm_mant   = s2_prod[PROD_W-2:MANT_W-1];
            nrm_guard  = s2_prod[MANT_W-2];
            nrm_sticky = |s2_prod[MANT_W-3:0];
            nrm_exp    = s2_exp;
        end
    end

    logic                     s3_sign;
    fclass_e                  s3_cls;
    logic signed [SEXP_W-1:0] s3_exp;
    logic [MANT_W-1:0]        s3_mant;
    logic                     s3_guard;
    logic                     s3_sticky;

    always_ff @(posedge clock or negedge aclr) begin
        if (!aclr) begin
            s3_sign   <= 1'b0;
            s3_cls    <= ZERO;
            s3_exp    <= '0;
            s3_mant   <= '0;
            s3_guard  <= 1'b0;
            s3_sticky <= 1'b0;
        end else begin
            s3_sign   <= s2_sign;
            s3_cls    <= s2_cls;
            s3_exp    <= nrm_exp;
            s3_mant   <= nrm_mant;
            s3_guard  <= nrm_guard;
            s3_sticky <= nrm_sticky;
        end
    end

    // ---------------- S4: round, range check ----------------
    logic [FRAC_W-1:0] rnd_frac;
    logic [EXP_W-1:0]  rnd_exp;
    logic              rnd_ovf;
    logic              rnd_unf;

    fp_mul_round u_round (
        .mant      (s3_mant),
        .guard     (s3_guard),
        .sticky    (s3_sticky),
        .exp_in    (s3_exp),
        .frac      (rnd_frac),
        .exp_out   (rnd_exp),
        .overflow  (rnd_ovf),
        .underflow (rnd_unf)
    );

    logic              s4_sign;
    fclass_e           s4_cls;
    logic [FRAC_W-1:0] s4_frac;
    logic [EXP_W-1:0]  s4_exp;
    logic              s4_ovf;
    logic              s4_unf;

    always_ff @(posedge clock or negedge aclr) begin
        if (!aclr) begin
            s4_sign <= 1'b0;
            s4_cls  <= ZERO;
            s4_frac <= '0;
            s4_exp  <= '0;
            s4_ovf  <= 1'b0;
            s4_unf  <= 1'b0;
        end else begin
            s4_sign <= s3_sign;
            s4_cls  <= s3_cls;
            s4_frac <= rnd_frac;
            s4_exp  <= rnd_exp;
            s4_ovf  <= rnd_ovf;
            s4_unf  <= rnd_unf;
        end
    end

    // ---------------- S5: pack ----------------
    // Specials override arithmetic; range limits only apply to NORM products.
    logic [FP_W-1:0] packed_res;

    always_comb begin
        packed_res = '0;
        unique case (s4_cls)
            NAN:     packed_res = QNAN;
            INF:     packed_res = {s4_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            ZERO:    packed_res = {s4_sign, {(FP_W-1){1'b0}}};
            default: begin
                if (s4_ovf) begin
                    packed_res = {s4_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                end else if (s4_unf) begin
                    packed_res = {s4_sign, {(FP_W-1){1'b0}}};
                end else begin
                    packed_res = {s4_sign, s4_exp, s4_frac};
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge aclr) begin
        if (!aclr) begin
            result <= '0;
        end else begin
            result <= packed_res;
        end
    end

`ifdef FP_MUL_FLAGS_EN
    always_ff @(posedge clock or negedge aclr) begin
        if (!aclr) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
            nan       <= 1'b0;
            zero      <= 1'b0;
        end else begin
            overflow  <= (s4_cls == NORM) && s4_ovf;
            underflow <= (s4_cls == NORM) && !s4_ovf && s4_unf;
            nan       <= (s4_cls == NAN);
            zero      <= (s4_cls == ZERO) || ((s4_cls == NORM) && !s4_ovf && s4_unf);
        end
    end
`endif

endmodule

// File: tb/tb_fp_mul.sv
// Directed bench for fp_mul: reset, streamed arithmetic/specials/limits, mid-stream reset.
// Latency: checks the product lands 5 edges after sampling, one per clock.
// Backpressure: none in the DUT; inputs change every cycle.
module tb_fp_mul;

    localparam int LAT = 5;
    localparam int N   = 16;

    logic        clock = 1'b0;
    logic        aclr  = 1'b0;
    logic [31:0] dataa = '0;
    logic [31:0] datab = '0;
    logic [31:0] result;
`ifdef FP_MUL_FLAGS_EN
    logic        overflow;
    logic        underflow;
    logic        nan;
    logic        zero;
`endif

    fp_mul dut (
        .clock     (clock),
        .aclr      (aclr),
        .dataa     (dataa),
        .datab     (datab),
        .result    (result)
`ifdef FP_MUL_FLAGS_EN
        ,
        .overflow  (overflow),
        .underflow (underflow),
        .nan       (nan),
        .zero      (zero)
`endif
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag, input logic [3:0] exp);
`ifdef FP_MUL_FLAGS_EN
        check({tag, "_flags"}, {28'd0, overflow, underflow, nan, zero}, {28'd0, exp});
`else
        if (exp === 4'hx) $display("unreachable %s", tag);
`endif
    endtask

    // Vector table: operands, expected product, expected {overflow,underflow,nan,zero}.
    logic [31:0] va [N];
    logic [31:0] vb [N];
    logic [31:0] ve [N];
    logic [3:0]  vf [N];
    string       vn [N];

    initial begin
        va[0]  = 32'h41700000; vb[0]  = 32'h40800000; ve[0]  = 32'h42700000; vf[0]  = 4'b0000; vn[0]  = "15x4";
        va[1]  = 32'h3F800000; vb[1]  = 32'h3F800000; ve[1]  = 32'h3F800000; vf[1]  = 4'b0000; vn[1]  = "1x1";
        va[2]  = 32'hC0000000; vb[2]  = 32'h40400000; ve[2]  = 32'hC0C00000; vf[2]  = 4'b0000; vn[2]  = "m2x3";
        va[3]  = 32'h3FC00000; vb[3]  = 32'h3FC00000; ve[3]  = 32'h40100000; vf[3]  = 4'b0000; vn[3]  = "1p5x1p5";
        va[4]  = 32'h3F800001; vb[4]  = 32'h3F800001; ve[4]  = 32'h3F800002; vf[4]  = 4'b0000; vn[4]  = "rnd_below_half";
        va[5]  = 32'h3FC00001; vb[5]  = 32'h3F800001; ve[5]  = 32'h3FC00003; vf[5]  = 4'b0000; vn[5]  = "rnd_above_half";
        va[6]  = 32'h3F800001; vb[6]  = 32'h3FC00000; ve[6]  = 32'h3FC00002; vf[6]  = 4'b0000; vn[6]  = "tie_to_even_up";
        va[7]  = 32'h3F800003; vb[7]  = 32'h3FC00000; ve[7]  = 32'h3FC00004; vf[7]  = 4'b0000; vn[7]  = "tie_to_even_down";
        va[8]  = 32'h7F800000; vb[8]  = 32'h00000000; ve[8]  = 32'h7FC00000; vf[8]  = 4'b0010; vn[8]  = "inf_x_zero";
        va[9]  = 32'h7F800000; vb[9]  = 32'hBF800000; ve[9]  = 32'hFF800000; vf[9]  = 4'b0000; vn[9]  = "inf_x_m1";
        va[10] = 32'h7F800001; vb[10] = 32'h3F800000; ve[10] = 32'h7FC00000; vf[10] = 4'b0010; vn[10] = "nan_x_1";
        va[11] = 32'h80000000; vb[11] = 32'h40000000; ve[11] = 32'h80000000; vf[11] = 4'b0001; vn[11] = "mzero_x_2";
        va[12] = 32'h7F000000; vb[12] = 32'h40000000; ve[12] = 32'h7F800000; vf[12] = 4'b1000; vn[12] = "overflow";
        va[13] = 32'h00800000; vb[13] = 32'h3F000000; ve[13] = 32'h00000000; vf[13] = 4'b0101; vn[13] = "underflow";
        va[14] = 32'h00000001; vb[14] = 32'h3F800000; ve[14] = 32'h00000000; vf[14] = 4'b0001; vn[14] = "subnorm_in";
        va[15] = 32'h7FC00000; vb[15] = 32'h7F800000; ve[15] = 32'h7FC00000; vf[15] = 4'b0010; vn[15] = "qnan_x_inf";

        // Reset held with live operands on the inputs: output must stay cleared.
        dataa = 32'h41700000;
        datab = 32'h40800000;
        #1;
        check("reset_async", result, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("reset_hold", result, 32'h0);
            check_flags("reset_hold", 4'b0000);
        end

        // Release and stream the table back-to-back; op i is checked LAT cycles later.
        aclr = 1'b1;
        for (int i = 0; i < N + LAT; i++) begin
            if (i >= LAT) begin
                check(vn[i-LAT], result, ve[i-LAT]);
                check_flags(vn[i-LAT], vf[i-LAT]);
            end else if (i > 0) begin
                check("pre_first", result, 32'h0);
            end
            if (i < N) begin
                dataa = va[i];
                datab = vb[i];
            end else begin
                dataa = 32'h0;
                datab = 32'h0;
            end
            @(negedge clock);
        end

        // Fill the pipe with 1.0x1.0, then three distinct products, then reset.
        dataa = 32'h3F800000;
        datab = 32'h3F800000;
        repeat (LAT) @(negedge clock);
        check("pre_reset_value", result, 32'h3F800000);
        dataa = 32'h41700000; datab = 32'h40800000; @(negedge clock);
        dataa = 32'hC0000000; datab = 32'h40400000; @(negedge clock);
        dataa = 32'h3FC00000; datab = 32'h3FC00000; @(negedge clock);
        check("pre_reset_still_1", result, 32'h3F800000);
        #2;
        aclr = 1'b0;
        #1;
        check("midstream_async_clear", result, 32'h0);
        dataa = 32'h0;
        datab = 32'h0;
        @(negedge clock);
        aclr = 1'b1;
        for (int k = 0; k < LAT + 3; k++) begin
            @(negedge clock);
            check("no_ghost_product", result, 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
